// File: rtl/ifu_axi_bridge.sv
// ---------------------------------------------------------------------------
// ifu_axi_bridge
//   Turns single instruction-fetch read requests into single-beat AXI4 reads.
//   One transaction is outstanding at a time. A flush (redirect) discards the
//   in-flight fetch: the AXI transfer still runs to completion, but no
//   response is reported and the response registers keep their old contents.
//
// Handshakes:
//   AXI AR and R follow strict valid/ready semantics. A beat transfers on a
//   rising edge where valid and ready are both 1. arvalid, once raised, stays
//   high with araddr/arsize stable until arready is seen, even under flush.
//   rready is high only in DATA. rvalid in any other state is ignored.
//   The fetch side has no backpressure. req_valid_i is accepted only in IDLE
//   with flush_i low. rsp_ready_o is a one-cycle pulse that qualifies
//   rsp_data_o / rsp_err_o.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_valid_i       fetch request strobe
//   req_addr_i        fetch byte address
//   req_size_i        byte-lane mask (0x01/0x03/0x0F/0xFF)
//   flush_i           redirect, drop the in-flight fetch
//   rsp_ready_o       response pulse
//   rsp_data_o        response data, selected word placed in [31:0]
//   rsp_err_o         AXI error on this response
//   ar*/r*            AXI4 read address / read data channels
//   dbg_state_o       current FSM state (0 IDLE, 1 ADDR, 2 DATA, 3 RESP)
// ---------------------------------------------------------------------------
module ifu_axi_bridge #(
  parameter int ID_W     = 4,
  parameter int FETCH_ID = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  input  logic [31:0]     req_addr_i,
  input  logic [7:0]      req_size_i,
  input  logic            flush_i,
  output logic            rsp_ready_o,
  output logic [63:0]     rsp_data_o,
  output logic            rsp_err_o,
  output logic            arvalid,
  input  logic            arready,
  output logic [31:0]     araddr,
  output logic [ID_W-1:0] arid,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  input  logic            rvalid,
  output logic            rready,
  input  logic [63:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  output logic [1:0]      dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_drop;

  logic        w_err;
  logic        w_drop_now;
  logic [63:0] w_rsp_data;
  logic        w_unused;

  // Only single-beat bursts are issued, so rlast carries no information.
  assign w_unused = rlast;

  assign arid        = ID_W'(FETCH_ID);
  assign arlen       = 8'd0;
  assign arburst     = 2'b01;
  assign dbg_state_o = r_state;

  // Byte-lane mask to AXI size; unexpected masks fall back to a word fetch.
  function automatic logic [2:0] decode_size(input logic [7:0] mask);
    logic [2:0] sz;
    case (mask)
      8'h01:   sz = 3'd0;
      8'h03:   sz = 3'd1;
      8'h0F:   sz = 3'd2;
      8'hFF:   sz = 3'd3;
      default: sz = 3'd2;
    endcase
    return sz;
  endfunction

  // araddr holds the latched address for the whole transaction, so its bit 2
  // selects which 32-bit half of the beat lands in rsp_data_o[31:0].
  always_comb begin
    w_err      = (rresp != 2'b00);
    w_rsp_data = {rdata[63:32], (araddr[2] ? rdata[63:32] : rdata[31:0])};
    if (w_err) begin
      w_rsp_data = 64'd0;
    end
  end

  // A flush arriving in the very cycle of the R handshake must also drop it.
  assign w_drop_now = r_drop | flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_drop      <= 1'b0;
      arvalid     <= 1'b0;
      araddr      <= 32'd0;
      arsize      <= 3'd0;
      rready      <= 1'b0;
      rsp_ready_o <= 1'b0;
      rsp_data_o  <= 64'd0;
      rsp_err_o   <= 1'b0;
    end else begin
      rsp_ready_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_drop <= 1'b0;
          if (req_valid_i && !flush_i) begin
            araddr  <= req_addr_i;
            arsize  <= decode_size(req_size_i);
            arvalid <= 1'b1;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (flush_i) begin
            r_drop <= 1'b1;
          end
          // arvalid is never withdrawn here; flush only marks the drop.
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (flush_i) begin
            r_drop <= 1'b1;
          end
          if (rvalid && rready) begin
            rready  <= 1'b0;
            r_state <= S_RESP;
            if (!w_drop_now) begin
              rsp_ready_o <= 1'b1;
              rsp_data_o  <= w_rsp_data;
              rsp_err_o   <= w_err;
            end
          end
        end
        S_RESP: begin
          // Drop flag is cleared as the FSM re-enters IDLE.
          r_drop  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
